// File: rtl/freq_div_n.sv
// Programmable 50%-duty integer clock divider (N = 2..2^WIDTH-1, runtime-loaded at period edges).
// Optional one-cycle period-start strobe on `tick` when FREQ_DIV_TICK_EN is defined.
module freq_div_n #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_RESET = 3
) (
  input  logic             clk,
  input  logic             reset_ah_in,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_pending,
  output logic             clk_out
`ifdef FREQ_DIV_TICK_EN
  ,
  output logic             tick
`endif
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_div_q, active_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic             pos_q, pos_d;
  logic             neg_q;

  logic             enabled;
  logic             is_odd;
  logic             at_boundary;
  logic [WIDTH-1:0] half_div;
  logic [WIDTH-1:0] last_idx;

  // cnt_q holds the phase index k of the upcoming posedge.
  always_comb begin
    enabled      = (active_div_q >= WIDTH'(2));
    is_odd       = active_div_q[0];
    half_div     = active_div_q >> 1;
    last_idx     = active_div_q - WIDTH'(1);
    at_boundary  = enabled && (cnt_q == last_idx);

    cnt_d        = cnt_q;
    active_div_d = active_div_q;
    pend_div_d   = pend_div_q;
    pending_d    = pending_q;
    pos_d        = 1'b0;

    if (!enabled) begin
      // Disabled: every edge is a boundary, so a load takes effect immediately.
      cnt_d     = '0;
      pending_d = 1'b0;
      if (div_load) begin
        active_div_d = div_val;
      end
    end else begin
      pos_d = (cnt_q < half_div);
      if (at_boundary) begin
        cnt_d     = '0;
        pending_d = 1'b0;
        if (div_load) begin
          active_div_d = div_val;
        end else if (pending_q) begin
          active_div_d = pend_div_q;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
        if (div_load) begin
          pend_div_d = div_val;
          pending_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) begin
      cnt_q        <= '0;
      active_div_q <= WIDTH'(DIV_RESET);
      pend_div_q   <= '0;
      pending_q    <= 1'b0;
      pos_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      active_div_q <= active_div_d;
      pend_div_q   <= pend_div_d;
      pending_q    <= pending_d;
      pos_q        <= pos_d;
    end
  end

  // Held at 0 outside odd mode so an even->odd switch cannot inherit a stale half-cycle.
  always_ff @(negedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= (enabled && is_odd) ? pos_q : 1'b0;
    end
  end

  assign clk_out     = is_odd ? (pos_q | neg_q) : pos_q;
  assign div_pending = pending_q;

`ifdef FREQ_DIV_TICK_EN
  logic tick_q;

  always_ff @(posedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= enabled && (cnt_q == '0);
    end
  end

  assign tick = tick_q;
`endif

endmodule

// File: tb/tb_freq_div_n.sv
// Randomized bench for freq_div_n against a half-cycle-level reference model.
module tb_freq_div_n;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned DIV_RESET = 3;

  logic             clk;
  logic             reset_ah_in;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             div_pending;
  logic             clk_out;
`ifdef FREQ_DIV_TICK_EN
  logic             tick;
`endif

  freq_div_n #(
    .WIDTH     (WIDTH),
    .DIV_RESET (DIV_RESET)
  ) dut (
    .clk         (clk),
    .reset_ah_in (reset_ah_in),
    .div_val     (div_val),
    .div_load    (div_load),
    .div_pending (div_pending),
    .clk_out     (clk_out)
`ifdef FREQ_DIV_TICK_EN
    ,
    .tick        (tick)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: a period of N clocks is 2N half-cycles, the first N of them high.
  int m_n;        // active divisor
  int m_k;        // phase index of the next posedge
  bit m_pend;
  int m_pend_val;
  bit m_en;       // state for the cycle following the last posedge
  int m_cur_k;
  int m_cur_n;

  function automatic void model_reset();
    m_n = DIV_RESET; m_k = 0; m_pend = 0; m_pend_val = 0;
    m_en = 0; m_cur_k = 0; m_cur_n = DIV_RESET;
  endfunction

  function automatic void model_edge(input bit ld, input int val);
    m_cur_n = m_n;
    if (m_n >= 2) begin
      m_en    = 1;
      m_cur_k = m_k;
      if (m_k == m_n - 1) begin
        if (ld) m_n = val;
        else if (m_pend) m_n = m_pend_val;
        m_pend = 0;
        m_k    = 0;
      end else begin
        m_k++;
        if (ld) begin
          m_pend     = 1;
          m_pend_val = val;
        end
      end
    end else begin
      m_en    = 0;
      m_cur_k = 0;
      if (ld) m_n = val;
      m_k = 0;
    end
  endfunction

  function automatic bit exp_high(input int half);
    return m_en && ((2 * m_cur_k + half) < m_cur_n);
  endfunction

  // Called just after a negedge; applies inputs across one full clock and checks both halves.
  task automatic step(input bit ld, input int val);
    div_load = ld;
    div_val  = WIDTH'(val);
    @(posedge clk);
    model_edge(ld, val);
    #1;
    div_load = 1'b0;
    check("clk_out_hi_half", 32'(clk_out), 32'(exp_high(0)));
    check("div_pending", 32'(div_pending), 32'(m_pend));
`ifdef FREQ_DIV_TICK_EN
    check("tick", 32'(tick), 32'(m_en && m_cur_k == 0));
`endif
    @(negedge clk);
    #1;
    check("clk_out_lo_half", 32'(clk_out), 32'(exp_high(1)));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0);
  endtask

  // Idle until the next posedge is phase 0 of an enabled period.
  task automatic sync_k0();
    int guard = 0;
    while (!(m_n >= 2 && m_k == 0) && guard < 300) begin
      step(0, 0);
      guard++;
    end
    if (guard >= 300) check("sync_k0_timeout", 32'(guard), 32'(0));
  endtask

  initial begin
    reset_ah_in = 1'b1;
    div_load    = 1'b0;
    div_val     = '0;
    model_reset();
    #3;
    check("rst_clk_out", 32'(clk_out), 32'(0));
    check("rst_div_pending", 32'(div_pending), 32'(0));
`ifdef FREQ_DIV_TICK_EN
    check("rst_tick", 32'(tick), 32'(0));
`endif
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_ah_in = 1'b0;

    run(9);                          // reset divisor 3
    step(0, 0);
    step(1, 4);                      // mid-period load of 4
    run(12);
    sync_k0();
    step(1, 7);                      // overwritten before the boundary
    step(1, 5);
    run(15);
    step(1, 0);                      // disable at next boundary
    run(10);
    step(1, 2);                      // immediate apply while disabled
    run(8);
    step(1, 255);
    run(520);
    step(1, 6);
    run(8);

    // Reset mid-period while clk_out is high and a load is pending.
    sync_k0();
    div_load = 1'b1;
    div_val  = WIDTH'(9);
    @(posedge clk);
    model_edge(1, 9);
    #1;
    div_load = 1'b0;
    check("pre_rst_clk_out", 32'(clk_out), 32'(1));
    check("pre_rst_pending", 32'(div_pending), 32'(1));
    #1;
    reset_ah_in = 1'b1;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 32'(0));
    check("async_rst_pending", 32'(div_pending), 32'(0));
    @(negedge clk);
    #1;
    reset_ah_in = 1'b0;
    model_reset();
    run(9);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) step(1, int'($urandom_range(0, 12)));
        else step(1, int'($urandom_range(0, 255)));
      end else begin
        step(0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t: got running, expected finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/freq_div_n.md
Name: freq_div_n

Overview:
Programmable integer clock divider, the parametrised successor of the fixed divide-by-3 block. It divides clk by any runtime-selected N in 2..2^WIDTH-1 and produces a 50% duty-cycle output for both odd and even N. Odd N uses a posedge phase register plus a negedge half-cycle extension. Divisor changes are queued and applied only at a period boundary, so clk_out never produces a runt pulse. It sits in the clock-generation area and feeds local slow-clock or strobe consumers.

Parameters:
WIDTH, 8, bit width of divisor and period counter
DIV_RESET, 3, active divisor after reset; must be 0 or in 2..2^WIDTH-1

Ports:
clk  input  1  source clock
reset_ah_in  input  1  asynchronous active-high reset; applies to posedge and negedge flops
div_val  input  WIDTH  requested divisor N
div_load  input  1  single-cycle strobe; samples div_val on the posedge
div_pending  output  1  high while a loaded divisor waits for the period boundary
clk_out  output  1  divided clock, 50% duty cycle
tick  output  1  one-clk pulse at period start (only with FREQ_DIV_TICK_EN)

Behaviour:
- Reset (async): cnt=0, active_div=DIV_RESET, pend_div=0, div_pending=0, pos_q=0, neg_q=0, clk_out=0, tick=0.
- Enabled when active_div>=2. Disabled when active_div is 0 or 1:
  - cnt held at 0; pos_q=neg_q=0; clk_out=0; tick=0.
- Period counter, posedge: cnt runs 0..N-1 and wraps to 0 (N=active_div). The first posedge after reset release (enabled) is k=0.
- pos_q is registered on posedge: high during posedge-cycles k=0..floor(N/2)-1, low otherwise.
- neg_q samples pos_q on negedge, i.e. pos_q delayed by half a clk.
- Output select:
  - N even: clk_out = pos_q, giving N/2 cycles high.
  - N odd: clk_out = pos_q | neg_q, giving floor(N/2)+0.5 = N/2 cycles high.
  - The odd/even select is taken from active_div, so it is stable within a period.
- Divisor update:
  - div_load=1 copies div_val to pend_div and sets div_pending.
  - A second load before application overwrites pend_div (last wins).
  - Application happens on the posedge where cnt==N-1: active_div<=pend_div, cnt<=0, div_pending<=0. The new period starts with the new N.
  - A load on the same posedge as cnt==N-1 is applied at that edge, and div_pending never rises.
  - If disabled, a load applies on the next posedge. Counting starts (k=0) on the posedge after that.
  - Loading the same value as active_div is legal and still follows the boundary rule.
- Reset mid-period aborts immediately: clk_out goes low asynchronously and any pending divisor is discarded.
- Latency: clk_out rises on the posedge at k=0, and with a half-cycle lag on neg_q the falling edge is at N/2 clk periods. All outputs are glitch-free. clk_out is the OR of two flops only in odd mode, where the flops' edges are a half-cycle apart.

Optional Feature:
FREQ_DIV_TICK_EN
- Defined: tick port exists and is registered high for exactly one clk cycle at each k=0 (enabled only). tick is 0 when disabled.
- Undefined: tick port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset release with DIV_RESET=3 -> clk_out period 3 clk, high 1.5 clk, low 1.5 clk; tick every 3rd posedge.
- Load N=4 mid-period of N=3 -> div_pending=1 until the cnt==2 edge; then period 4, high exactly 2 clk; no short pulse across the switch.
- Load N=7, then N=5 one cycle later, both before the boundary -> N=5 applied (period 5, high 2.5 clk); 7 never seen.
- Load N=0 -> after the boundary clk_out=0 and tick=0 steady; then load N=2 -> next posedge applies, following posedge starts period 2, high 1 clk.
- WIDTH=8, load N=255 -> period 255, high 127.5 clk; cnt wraps 254->0 cleanly.
- Assert reset_ah_in between posedges while clk_out=1 -> clk_out drops immediately; div_pending cleared; after release the period restarts with DIV_RESET.
